// File: rtl/pc_seq_ctrl.sv
// Fetch/decode/execute sequencer feeding nbit_pc: latches the addressed instruction,
// issues one PC control command per instruction and counts retired instructions.
module pc_seq_ctrl #(
    parameter int N   = 4,
    parameter int OPW = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [OPW+N-1:0] instr,
    input  logic [N-1:0]     pc_out,
    input  logic             flag_z,
    output logic [1:0]       ctrl,
    output logic [N-1:0]     pc_in,
    output logic [OPW+N-1:0] ir,
    output logic [1:0]       state,
    output logic             halted,
    output logic [7:0]       icount
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_HALT   = 2'b11
    } state_t;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_LOAD = 2'b01;
    localparam logic [1:0] CTRL_INC1 = 2'b10;
    localparam logic [1:0] CTRL_INC2 = 2'b11;

    localparam logic [OPW-1:0] OP_JMP  = OPW'(1);
    localparam logic [OPW-1:0] OP_JZ   = OPW'(2);
    localparam logic [OPW-1:0] OP_SKIP = OPW'(3);
    localparam logic [OPW-1:0] OP_HLT  = '1;

    state_t           state_reg,  state_next;
    logic [OPW+N-1:0] ir_reg,     ir_next;
    logic [1:0]       ctrl_reg,   ctrl_next;
    logic [N-1:0]     pc_in_reg,  pc_in_next;
    logic             halted_reg, halted_next;
    logic [7:0]       icount_reg, icount_next;

    logic [OPW-1:0]   opcode;
    logic [N-1:0]     operand;

    assign opcode  = ir_reg[OPW+N-1:N];
    assign operand = ir_reg[N-1:0];

    // PC wrap belongs to nbit_pc, so the current PC never influences sequencing.
    logic unused_pc_out;
    assign unused_pc_out = ^pc_out;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg  <= S_FETCH;
            ir_reg     <= '0;
            ctrl_reg   <= CTRL_HOLD;
            pc_in_reg  <= '0;
            halted_reg <= 1'b0;
            icount_reg <= 8'd0;
        end else begin
            state_reg  <= state_next;
            ir_reg     <= ir_next;
            ctrl_reg   <= ctrl_next;
            pc_in_reg  <= pc_in_next;
            halted_reg <= halted_next;
            icount_reg <= icount_next;
        end
    end

    // ctrl defaults to hold so a non-zero command lives for exactly the EXECUTE cycle.
    always_comb begin
        state_next  = state_reg;
        ir_next     = ir_reg;
        ctrl_next   = CTRL_HOLD;
        pc_in_next  = pc_in_reg;
        halted_next = halted_reg;
        icount_next = icount_reg;

        case (state_reg)
            S_FETCH: begin
                if (run) begin
                    ir_next    = instr;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
                case (opcode)
                    OP_JMP: begin
                        ctrl_next  = CTRL_LOAD;
                        pc_in_next = operand;
                    end
                    OP_JZ: begin
                        if (flag_z) begin
                            ctrl_next  = CTRL_LOAD;
                            pc_in_next = operand;
                        end else begin
                            ctrl_next  = CTRL_INC1;
                        end
                    end
                    OP_SKIP: begin
                        ctrl_next = CTRL_INC2;
                    end
                    OP_HLT: begin
                        state_next  = S_HALT;
                        halted_next = 1'b1;
                        icount_next = icount_reg + 8'd1;
                    end
                    default: begin
                        ctrl_next = CTRL_INC1;
                    end
                endcase
            end
            S_EXEC: begin
                state_next  = S_FETCH;
                icount_next = icount_reg + 8'd1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign ctrl   = ctrl_reg;
    assign pc_in  = pc_in_reg;
    assign ir     = ir_reg;
    assign state  = state_reg;
    assign halted = halted_reg;
    assign icount = icount_reg;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: an instruction-level interpreter predicts each
// retired instruction; a negedge monitor compares whenever the sequencer executes or halts.
module tb_pc_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic       flag_z = 1'b0;
    logic [7:0] instr = 8'h00;
    logic [3:0] pc_env;
    logic [1:0] ctrl;
    logic [3:0] pc_in;
    logic [7:0] ir;
    logic [1:0] state;
    logic       halted;
    logic [7:0] icount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         halt;
        logic [1:0] ctrl;
        logic [3:0] pc_in;
        logic [3:0] pc;
        logic [7:0] ir;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] imem[16];
    logic [3:0] mpc;
    logic [3:0] mpc_in;
    logic [7:0] mcount;
    bit         mon_en = 1'b1;
    bit         halt_seen = 1'b0;

    pc_seq_ctrl #(.N(4), .OPW(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .run    (run),
        .instr  (instr),
        .pc_out (pc_env),
        .flag_z (flag_z),
        .ctrl   (ctrl),
        .pc_in  (pc_in),
        .ir     (ir),
        .state  (state),
        .halted (halted),
        .icount (icount)
    );

    always #5 clk = ~clk;

    // Stand-in for nbit_pc.
    always @(posedge clk or posedge clr) begin
        if (clr) pc_env <= 4'd0;
        else begin
            case (ctrl)
                2'b01:   pc_env <= pc_in;
                2'b10:   pc_env <= pc_env + 4'd1;
                2'b11:   pc_env <= pc_env + 4'd2;
                default: pc_env <= pc_env;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (state != 2'b11) halt_seen = 1'b0;
        if (!clr && mon_en && (state == 2'b10 || (state == 2'b11 && !halt_seen))) begin
            if (state == 2'b11) halt_seen = 1'b1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_retire: state %0d with empty scoreboard at %0t", state, $time);
            end else begin
                mon_e = q.pop_front();
                $display("retire pc=%0h ir=%02h ctrl=%0d pc_in=%0h icount=%0d", pc_env, ir, ctrl, pc_in, icount);
                chk("kind",   32'(state),  mon_e.halt ? 32'd3 : 32'd2);
                chk("ctrl",   32'(ctrl),   32'(mon_e.ctrl));
                chk("pc_in",  32'(pc_in),  32'(mon_e.pc_in));
                chk("ir",     32'(ir),     32'(mon_e.ir));
                chk("icount", 32'(icount), 32'(mon_e.cnt));
                chk("pc",     32'(pc_env), 32'(mon_e.pc));
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] ins, input logic fz);
        run = r;
        instr = ins;
        flag_z = fz;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk("pending", 32'(q.size()), 32'd0);
        q.delete();
        clr = 1'b1;
        #2;
        chk("rst_state",  32'(state),  32'd0);
        chk("rst_ctrl",   32'(ctrl),   32'd0);
        chk("rst_icount", 32'(icount), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ir",     32'(ir),     32'd0);
        chk("rst_pc_in",  32'(pc_in),  32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        mpc = 4'd0;
        mpc_in = 4'd0;
        mcount = 8'd0;
    endtask

    // Architectural interpretation of one instruction, then drive its cycles.
    task automatic exec_one(input int stalls, input int fz_force, output bit did_halt);
        exp_t       e;
        logic [7:0] w;
        logic [3:0] op;
        logic [3:0] opr;
        logic       fz;
        w = imem[mpc];
        op = w[7:4];
        opr = w[3:0];
        fz = (fz_force < 0) ? 1'($urandom) : 1'(fz_force);
        e.halt = 1'b0;
        e.ir = w;
        e.pc = mpc;
        e.cnt = mcount;
        case (op)
            4'h1: begin e.ctrl = 2'b01; mpc_in = opr; mpc = opr; end
            4'h2: begin
                if (fz) begin e.ctrl = 2'b01; mpc_in = opr; mpc = opr; end
                else begin e.ctrl = 2'b10; mpc = mpc + 4'd1; end
            end
            4'h3: begin e.ctrl = 2'b11; mpc = mpc + 4'd2; end
            4'hF: begin e.ctrl = 2'b00; e.halt = 1'b1; end
            default: begin e.ctrl = 2'b10; mpc = mpc + 4'd1; end
        endcase
        mcount = mcount + 8'd1;
        if (e.halt) e.cnt = mcount;
        e.pc_in = mpc_in;
        if (mon_en) q.push_back(e);

        for (int i = 0; i < stalls; i++) begin
            step(1'b0, 8'($urandom), 1'($urandom));
            chk("stall_state", 32'(state), 32'd0);
            chk("stall_ctrl",  32'(ctrl),  32'd0);
        end
        step(1'b1, imem[pc_env], 1'($urandom));
        step(1'($urandom), 8'($urandom), fz);
        did_halt = e.halt;
        if (did_halt) begin
            for (int i = 0; i < 10; i++) begin
                step(1'($urandom), 8'($urandom), 1'($urandom));
                chk("halt_state",  32'(state),  32'd3);
                chk("halt_flag",   32'(halted), 32'd1);
                chk("halt_ctrl",   32'(ctrl),   32'd0);
                chk("halt_icount", 32'(icount), 32'(mcount));
                chk("halt_pc",     32'(pc_env), 32'(e.pc));
            end
        end else begin
            step(1'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    function automatic logic [7:0] rand_instr();
        int         r;
        logic [3:0] opr;
        r = $urandom_range(0, 9);
        opr = 4'($urandom);
        if (r < 3)      return {4'h0, opr};
        else if (r < 5) return {4'h1, opr};
        else if (r < 7) return {4'h2, opr};
        else if (r < 9) return {4'h3, opr};
        else            return {4'($urandom_range(4, 14)), opr};
    endfunction

    task automatic fill_zero();
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    endtask

    task automatic fill_rand(input bit allow_halt);
        for (int i = 0; i < 16; i++) imem[i] = rand_instr();
        if (allow_halt) imem[$urandom_range(1, 15)] = {4'hF, 4'($urandom)};
    endtask

    task automatic run_prog(input int n, input int max_stall, input int fz_force);
        bit h;
        for (int i = 0; i < n; i++) begin
            exec_one($urandom_range(0, max_stall), fz_force, h);
            if (h) break;
        end
    endtask

    initial begin
        mpc = 4'd0;
        mpc_in = 4'd0;
        mcount = 8'd0;
        do_reset();

        // NOP stream from PC 0
        fill_zero();
        run_prog(5, 0, -1);
        chk("nop_icount", 32'(icount), 32'd5);
        chk("nop_pc",     32'(pc_env), 32'd5);

        // clr during EXECUTE drops ctrl immediately
        mon_en = 1'b0;
        step(1'b1, imem[pc_env], 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("mid_exec_state", 32'(state), 32'd2);
        chk("mid_exec_ctrl",  32'(ctrl),  32'd2);
        clr = 1'b1;
        #1;
        chk("mid_clr_state",  32'(state),  32'd0);
        chk("mid_clr_ctrl",   32'(ctrl),   32'd0);
        chk("mid_clr_icount", 32'(icount), 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        // JMP and taken JZ
        fill_zero();
        imem[0] = 8'h1A;
        imem[10] = 8'h25;
        imem[5] = 8'h25;
        run_prog(4, 0, 1);
        do_reset();

        // JZ not taken keeps pc_in
        fill_zero();
        imem[0] = 8'h25;
        imem[1] = 8'h1A;
        run_prog(3, 0, 0);
        chk("jz_pc", 32'(pc_env), 32'd11);
        do_reset();

        // SKIP across the PC wrap
        fill_zero();
        imem[0] = 8'h1D;
        imem[13] = 8'h30;
        imem[15] = 8'h30;
        imem[1] = 8'h1E;
        imem[14] = 8'h30;
        run_prog(6, 0, -1);
        do_reset();

        // stall then halt
        fill_zero();
        imem[1] = 8'hF0;
        run_prog(2, 4, -1);
        chk("halt_reached", 32'(state), 32'd3);
        do_reset();

        // random programs
        for (int p = 0; p < 8; p++) begin
            fill_rand(1'b1);
            run_prog(40, 2, -1);
            do_reset();
        end

        // icount wrap
        fill_rand(1'b0);
        run_prog(270, 0, -1);
        chk("wrap_icount", 32'(icount), 32'(mcount));
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
